// File: rtl/store_drain_arbiter_if.sv
// Data-cache request/response channel shared by the arbiter (master) and the cache (slave).
// cache_access_size_t is declared here so both sides of the channel agree on the size encoding.
typedef logic [1:0] cache_access_size_t;

interface store_drain_arbiter_if #(
   parameter int unsigned ADDR_SIZE = 32,
   parameter int unsigned WORD_SIZE = 32
) ();
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_data;
   cache_access_size_t   req_size;
   logic                 resp_valid;
   logic [WORD_SIZE-1:0] rdata;

   modport master (
      output req_valid, req_write, req_addr, req_data, req_size,
      input  req_ready, resp_valid, rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_data, req_size,
      output req_ready, resp_valid, rdata
   );
endinterface

// File: rtl/store_drain_arbiter.sv
// Shares the single data-cache port between pipeline loads and the store buffer drain,
// one access in flight, with fence support and a load-starvation limit for stores.
module store_drain_arbiter #(
   parameter int unsigned ADDR_SIZE    = 32,
   parameter int unsigned WORD_SIZE    = 32,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   ld_valid_i,
   input  logic [ADDR_SIZE-1:0]   ld_addr_i,
   input  cache_access_size_t     ld_size_i,
   output logic                   ld_done_o,
   output logic [WORD_SIZE-1:0]   ld_data_o,
   input  logic [ADDR_SIZE-1:0]   sb_addr_i,
   input  logic [WORD_SIZE-1:0]   sb_data_i,
   input  cache_access_size_t     sb_size_i,
   input  logic                   sb_empty_i,
   input  logic                   sb_full_i,
   output logic                   sb_get_o,
   input  logic                   fence_i,
   output logic                   fence_done_o,
   store_drain_arbiter_if.master  cache
);

   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
   localparam logic [StarveW-1:0] StarveLimit = StarveW'(STARVE_LIMIT);

   typedef enum logic [2:0] {StIdle, StLdReq, StLdWait, StStReq, StStWait} state_e;

   state_e               state_q;
   logic [StarveW-1:0]   starve_q;
   logic                 req_valid_q;
   logic                 req_write_q;
   logic [ADDR_SIZE-1:0] req_addr_q;
   logic [WORD_SIZE-1:0] req_data_q;
   cache_access_size_t   req_size_q;
   logic                 drain_needed;

   // A waiting load yields to the store buffer only when the buffer is under pressure.
   assign drain_needed = !sb_empty_i &&
                         (sb_full_i || fence_i || (starve_q >= StarveLimit) || !ld_valid_i);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         starve_q    <= '0;
         req_valid_q <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_data_q  <= '0;
         req_size_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sb_empty_i) begin
                  starve_q <= '0;
               end
               if (drain_needed) begin
                  req_valid_q <= 1'b1;
                  req_write_q <= 1'b1;
                  req_addr_q  <= sb_addr_i;
                  req_data_q  <= sb_data_i;
                  req_size_q  <= sb_size_i;
                  starve_q    <= '0;
                  state_q     <= StStReq;
               end else if (ld_valid_i && !fence_i) begin
                  req_valid_q <= 1'b1;
                  req_write_q <= 1'b0;
                  req_addr_q  <= ld_addr_i;
                  req_data_q  <= '0;
                  req_size_q  <= ld_size_i;
                  if (!sb_empty_i && !(&starve_q)) begin
                     starve_q <= starve_q + StarveW'(1);
                  end
                  state_q     <= StLdReq;
               end
            end
            StLdReq: begin
               if (cache.req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= StLdWait;
               end
            end
            StLdWait: begin
               if (cache.resp_valid) begin
                  state_q <= StIdle;
               end
            end
            StStReq: begin
               if (cache.req_ready) begin
                  req_valid_q <= 1'b0;
                  state_q     <= StStWait;
               end
            end
            StStWait: begin
               if (cache.resp_valid) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               req_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign cache.req_valid = req_valid_q;
   assign cache.req_write = req_write_q;
   assign cache.req_addr  = req_addr_q;
   assign cache.req_data  = req_data_q;
   assign cache.req_size  = req_size_q;

   // Completion pulses coincide with the cache response; the store buffer pops on that edge.
   assign ld_done_o    = (state_q == StLdWait) && cache.resp_valid;
   assign sb_get_o     = (state_q == StStWait) && cache.resp_valid;
   assign ld_data_o    = cache.rdata;
   assign fence_done_o = fence_i && sb_empty_i && (state_q == StIdle);

endmodule

// File: tb/tb_store_drain_arbiter.sv
// Randomized bench for store_drain_arbiter: a store-buffer queue, load requester and cache
// responder drive the DUT while a transaction-level reference predicts every grant and pulse.
module tb_store_drain_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned WW    = 32;
   localparam int          LIMIT = 2;
   localparam int          DEPTH = 4;
   localparam int          NCYC  = 6000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } st_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               ld_valid;
   logic [AW-1:0]      ld_addr;
   cache_access_size_t ld_size;
   logic               ld_done;
   logic [WW-1:0]      ld_data;
   logic [AW-1:0]      sb_addr;
   logic [WW-1:0]      sb_data;
   cache_access_size_t sb_size;
   logic               sb_empty;
   logic               sb_full;
   logic               sb_get;
   logic               fence;
   logic               fence_done;

   store_drain_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) cif ();

   store_drain_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .STARVE_LIMIT(LIMIT)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .ld_valid_i   (ld_valid),
      .ld_addr_i    (ld_addr),
      .ld_size_i    (ld_size),
      .ld_done_o    (ld_done),
      .ld_data_o    (ld_data),
      .sb_addr_i    (sb_addr),
      .sb_data_i    (sb_data),
      .sb_size_i    (sb_size),
      .sb_empty_i   (sb_empty),
      .sb_full_i    (sb_full),
      .sb_get_o     (sb_get),
      .fence_i      (fence),
      .fence_done_o (fence_done),
      .cache        (cif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Environment state
   st_t         sbq[$];
   logic [31:0] ref_mem[16];
   logic [31:0] cache_mem[16];
   bit          ld_pend;
   logic [31:0] ld_a;
   logic [1:0]  ld_s;
   bit          fence_lvl;
   bit          rsp_pend;
   bit          rsp_wr;
   logic [31:0] rsp_addr;
   logic [31:0] rsp_data;

   // Reference: one outstanding access described by its grant fields and acceptance
   bit          m_busy;
   bit          m_acc;
   bit          m_wr;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   logic [1:0]  m_size;
   int          m_starve;

   int  n_loads;
   int  n_stores;
   int  n_resets;
   bit  reset_armed;

   task automatic drive_inputs();
      ld_valid = ld_pend;
      ld_addr  = ld_a;
      ld_size  = ld_s;
      sb_empty = (sbq.size() == 0);
      sb_full  = (sbq.size() == DEPTH);
      if (sbq.size() != 0) begin
         sb_addr = sbq[0].addr;
         sb_data = sbq[0].data;
         sb_size = sbq[0].size;
      end else begin
         sb_addr = '0;
         sb_data = '0;
         sb_size = '0;
      end
      fence          = fence_lvl;
      cif.req_ready  = ($urandom_range(0, 1) == 1);
      cif.resp_valid = ($urandom_range(0, 2) == 0);
      cif.rdata      = cache_mem[rsp_addr[5:2]];
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req_valid"}, 64'(cif.req_valid), 64'd0);
      check_eq({pfx, "_req_write"}, 64'(cif.req_write), 64'd0);
      check_eq({pfx, "_req_addr"}, 64'(cif.req_addr), 64'd0);
      check_eq({pfx, "_req_data"}, 64'(cif.req_data), 64'd0);
      check_eq({pfx, "_req_size"}, 64'(cif.req_size), 64'd0);
      check_eq({pfx, "_ld_done"}, 64'(ld_done), 64'd0);
      check_eq({pfx, "_sb_get"}, 64'(sb_get), 64'd0);
   endtask

   task automatic model_reset();
      m_busy   = 1'b0;
      m_acc    = 1'b0;
      m_starve = 0;
      rsp_pend = 1'b0;
   endtask

   task automatic check_cycle();
      bit exp_valid;
      bit exp_done;
      bit exp_get;
      exp_valid = m_busy && !m_acc;
      exp_done  = m_busy && m_acc && !m_wr && cif.resp_valid;
      exp_get   = m_busy && m_acc && m_wr && cif.resp_valid;
      check_eq("req_valid", 64'(cif.req_valid), 64'(exp_valid));
      if (exp_valid) begin
         check_eq("req_write", 64'(cif.req_write), 64'(m_wr));
         check_eq("req_addr", 64'(cif.req_addr), 64'(m_addr));
         check_eq("req_data", 64'(cif.req_data), 64'(m_data));
         check_eq("req_size", 64'(cif.req_size), 64'(m_size));
      end
      check_eq("ld_done", 64'(ld_done), 64'(exp_done));
      if (exp_done) begin
         check_eq("ld_data", 64'(ld_data), 64'(ref_mem[ld_a[5:2]]));
      end
      check_eq("sb_get", 64'(sb_get), 64'(exp_get));
      check_eq("fence_done", 64'(fence_done),
               64'(fence_lvl && (sbq.size() == 0) && !m_busy));
   endtask

   task automatic step_env_and_model();
      bit drain;
      st_t e;
      // Cache responder: a write takes effect only when its response is given
      if (cif.resp_valid && rsp_pend) begin
         if (rsp_wr) cache_mem[rsp_addr[5:2]] = rsp_data;
         rsp_pend = 1'b0;
      end
      if (cif.req_valid && cif.req_ready) begin
         rsp_pend = 1'b1;
         rsp_wr   = cif.req_write;
         rsp_addr = cif.req_addr;
         rsp_data = cif.req_data;
      end
      if (!m_busy) begin
         if (sbq.size() == 0) m_starve = 0;
         drain = (sbq.size() != 0) &&
                 ((sbq.size() == DEPTH) || fence_lvl || (m_starve >= LIMIT) || !ld_pend);
         if (drain) begin
            m_busy = 1'b1; m_acc = 1'b0; m_wr = 1'b1;
            m_addr = sbq[0].addr; m_data = sbq[0].data; m_size = sbq[0].size;
            m_starve = 0;
         end else if (ld_pend && !fence_lvl) begin
            m_busy = 1'b1; m_acc = 1'b0; m_wr = 1'b0;
            m_addr = ld_a; m_data = '0; m_size = ld_s;
            if (sbq.size() != 0) m_starve++;
         end
      end else if (!m_acc) begin
         if (cif.req_ready) m_acc = 1'b1;
      end else if (cif.resp_valid) begin
         m_busy = 1'b0;
         if (m_wr) begin
            ref_mem[sbq[0].addr[5:2]] = sbq[0].data;
            void'(sbq.pop_front());
            n_stores++;
         end else begin
            ld_pend = 1'b0;
            n_loads++;
         end
      end
      // New traffic for the next cycle
      if (!ld_pend && ($urandom_range(0, 3) != 0)) begin
         ld_pend = 1'b1;
         ld_a    = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         ld_s    = 2'($urandom_range(0, 2));
      end
      if ((sbq.size() < DEPTH) && ($urandom_range(0, 3) == 0)) begin
         e.addr = 32'h100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         e.data = $urandom;
         e.size = 2'($urandom_range(0, 2));
         sbq.push_back(e);
      end
      if ($urandom_range(0, 39) == 0) fence_lvl = !fence_lvl;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]   = 32'hDEADBEEF ^ (32'h01010101 * i);
         cache_mem[i] = ref_mem[i];
      end
      ld_pend = 1'b0; ld_a = '0; ld_s = '0; fence_lvl = 1'b0;
      rsp_addr = '0; rsp_wr = 1'b0; rsp_data = '0;
      n_loads = 0; n_stores = 0; n_resets = 0; reset_armed = 1'b0;
      model_reset();
      m_wr = 1'b0; m_addr = '0; m_data = '0; m_size = '0;

      reset = 1'b1;
      drive_inputs();
      cif.req_ready  = 1'b0;
      cif.resp_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #1 reset = 1'b0;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         drive_inputs();
         if ((cyc % 600) == 300) reset_armed = 1'b1;
         if (reset_armed && m_busy && m_acc && m_wr) begin
            // Abandon a store mid-wait with its response arriving: no pop may result
            reset_armed    = 1'b0;
            cif.resp_valid = 1'b1;
            reset          = 1'b1;
            #1;
            check_reset_outputs("mid_rst");
            model_reset();
            n_resets++;
            @(posedge clk);
            #1 reset = 1'b0;
         end
         @(negedge clk);
         check_cycle();
         step_env_and_model();
      end

      check_eq("loads_completed", 64'(n_loads > 20), 64'd1);
      check_eq("stores_drained", 64'(n_stores > 20), 64'd1);
      check_eq("mid_resets_taken", 64'(n_resets > 0), 64'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
